// File: rtl/connect_n_if.sv
// Button, board-read and status bundle for connect_n_game.
// The master side is the player/UI and the slave side is the game engine.
interface connect_n_if #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3
);
  logic                move_right;
  logic                move_left;
  logic                drop_piece;
  logic                new_game;
  logic                undo;
  logic [ROW_BITS-1:0] row_read;
  logic [COL_BITS-1:0] col_read;
  logic [1:0]          data_out;
  logic [COL_BITS-1:0] current_col;
  logic [1:0]          current_player;
  logic                busy;
  logic                game_over;
  logic                draw;
  logic [1:0]          winner;

  modport master (
    output move_right, move_left, drop_piece, new_game, undo, row_read, col_read,
    input  data_out, current_col, current_player, busy, game_over, draw, winner
  );

  modport slave (
    input  move_right, move_left, drop_piece, new_game, undo, row_read, col_read,
    output data_out, current_col, current_player, busy, game_over, draw, winner
  );
endinterface

// File: rtl/connect_n_game.sv
// Connect-N game engine: gravity drop, cell-per-cycle win scan, draw detection.
// Define CONNECT_N_UNDO_EN to enable single-level undo of the last drop.
module connect_n_game #(
  parameter int ROWS        = 6,
  parameter int COLS        = 7,
  parameter int ROW_BITS    = 3,
  parameter int COL_BITS    = 3,
  parameter int WIN_LEN     = 4,
  parameter int NUM_PLAYERS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  connect_n_if.slave bus
);
  localparam int CELLS    = ROWS * COLS;
  localparam int CNT_BITS = $clog2(CELLS + 1);

  typedef enum logic [2:0] {IDLE, DROP, CHECK, WIN, DRAW} state_t;

  // Synchronisers idle high so a button held through reset never produces an edge.
  logic [4:0] btn_raw, sync0_q, sync1_q, sync2_q, evt_q;
  assign btn_raw = {bus.undo, bus.new_game, bus.drop_piece, bus.move_left, bus.move_right};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= '1;
      sync1_q <= '1;
      sync2_q <= '1;
      evt_q   <= '0;
    end else begin
      sync0_q <= btn_raw;
      sync1_q <= sync0_q;
      sync2_q <= sync1_q;
      evt_q   <= sync1_q & ~sync2_q;
    end
  end

  logic ev_right, ev_left, ev_drop, ev_new;
  assign ev_right = evt_q[0];
  assign ev_left  = evt_q[1];
  assign ev_drop  = evt_q[2];
  assign ev_new   = evt_q[3];

  state_t              state_q, state_d;
  logic [1:0]          board_q [ROWS][COLS];
  logic [1:0]          board_d [ROWS][COLS];
  logic [COL_BITS-1:0] col_q, col_d;
  logic [1:0]          player_q, player_d;
  logic [1:0]          winner_q, winner_d;
  logic [1:0]          mover_q, mover_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [ROW_BITS-1:0] last_row_q, last_row_d;
  logic [COL_BITS-1:0] last_col_q, last_col_d;
  logic [1:0]          dir_q, dir_d;
  logic                side_q, side_d;
  logic [2:0]          step_q, step_d;
  logic [3:0]          run_q, run_d;
`ifdef CONNECT_N_UNDO_EN
  logic                hist_valid_q, hist_valid_d;
  logic                ev_undo;
  assign ev_undo = evt_q[4];
`else
  logic                unused_undo;
  assign unused_undo = evt_q[4];
`endif

  logic [1:0] next_player;
  assign next_player = (player_q == 2'(NUM_PLAYERS)) ? 2'd1 : player_q + 2'd1;

  logic [ROW_BITS-1:0] drop_row;
  logic                col_space;

  always_comb begin
    drop_row  = '0;
    col_space = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!col_space && board_q[r][col_q] == 2'b00) begin
        drop_row  = ROW_BITS'(r);
        col_space = 1'b1;
      end
    end
  end

  // Scan cell = last placed cell offset by step along dir; side 1 walks the negative way.
  int         chk_r, chk_c, d_r, d_c, sgn;
  logic       on_board, match;
  logic [1:0] scan_cell;

  always_comb begin
    sgn = side_q ? -1 : 1;
    d_r = 1;
    d_c = 0;
    case (dir_q)
      2'd0:    begin d_r = 0; d_c = 1;  end
      2'd1:    begin d_r = 1; d_c = 0;  end
      2'd2:    begin d_r = 1; d_c = 1;  end
      default: begin d_r = 1; d_c = -1; end
    endcase
    chk_r     = int'(last_row_q) + sgn * d_r * int'(step_q);
    chk_c     = int'(last_col_q) + sgn * d_c * int'(step_q);
    on_board  = (chk_r >= 0) && (chk_r < ROWS) && (chk_c >= 0) && (chk_c < COLS);
    scan_cell = '0;
    if (on_board) scan_cell = board_q[chk_r[ROW_BITS-1:0]][chk_c[COL_BITS-1:0]];
    match     = on_board && (scan_cell == mover_q);
  end

  logic side_end;

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    col_d      = col_q;
    player_d   = player_q;
    winner_d   = winner_q;
    mover_d    = mover_q;
    cnt_d      = cnt_q;
    last_row_d = last_row_q;
    last_col_d = last_col_q;
    dir_d      = dir_q;
    side_d     = side_q;
    step_d     = step_q;
    run_d      = run_q;
    side_end   = 1'b0;
`ifdef CONNECT_N_UNDO_EN
    hist_valid_d = hist_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (ev_right && !ev_left)
          col_d = (int'(col_q) == COLS - 1) ? '0 : col_q + 1'b1;
        else if (ev_left && !ev_right)
          col_d = (col_q == '0) ? COL_BITS'(COLS - 1) : col_q - 1'b1;
        if (ev_drop) begin
          state_d = DROP;
        end
`ifdef CONNECT_N_UNDO_EN
        else if (ev_undo && hist_valid_q) begin
          board_d[last_row_q][last_col_q] = '0;
          cnt_d        = cnt_q - 1'b1;
          player_d     = mover_q;
          hist_valid_d = 1'b0;
        end
`endif
      end
      DROP: begin
        if (col_space) begin
          board_d[drop_row][col_q] = player_q;
          cnt_d      = cnt_q + 1'b1;
          last_row_d = drop_row;
          last_col_d = col_q;
          mover_d    = player_q;
          dir_d      = 2'd0;
          side_d     = 1'b0;
          step_d     = 3'd1;
          run_d      = 4'd1;
          state_d    = CHECK;
`ifdef CONNECT_N_UNDO_EN
          hist_valid_d = 1'b1;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (match && (int'(run_q) + 1 == WIN_LEN)) begin
          winner_d = mover_q;
          state_d  = WIN;
        end else begin
          if (match) begin
            run_d    = run_q + 1'b1;
            step_d   = step_q + 1'b1;
            side_end = (int'(step_q) == WIN_LEN - 1);
          end else begin
            side_end = 1'b1;
          end
          // Run count carries across the two sides of one direction.
          if (side_end) begin
            step_d = 3'd1;
            if (!side_q) begin
              side_d = 1'b1;
            end else if (dir_q != 2'd3) begin
              dir_d  = dir_q + 1'b1;
              side_d = 1'b0;
              run_d  = 4'd1;
            end else if (int'(cnt_q) == CELLS) begin
              state_d = DRAW;
            end else begin
              player_d = next_player;
              state_d  = IDLE;
            end
          end
        end
      end
      default: ;
    endcase

    if (ev_new) begin
      board_d  = '{default: '0};
      cnt_d    = '0;
      winner_d = '0;
      player_d = 2'd1;
      col_d    = '0;
      state_d  = IDLE;
`ifdef CONNECT_N_UNDO_EN
      hist_valid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      board_q    <= '{default: '0};
      col_q      <= '0;
      player_q   <= 2'd1;
      winner_q   <= '0;
      mover_q    <= 2'd1;
      cnt_q      <= '0;
      last_row_q <= '0;
      last_col_q <= '0;
      dir_q      <= '0;
      side_q     <= 1'b0;
      step_q     <= 3'd1;
      run_q      <= 4'd1;
`ifdef CONNECT_N_UNDO_EN
      hist_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      col_q      <= col_d;
      player_q   <= player_d;
      winner_q   <= winner_d;
      mover_q    <= mover_d;
      cnt_q      <= cnt_d;
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
      dir_q      <= dir_d;
      side_q     <= side_d;
      step_q     <= step_d;
      run_q      <= run_d;
`ifdef CONNECT_N_UNDO_EN
      hist_valid_q <= hist_valid_d;
`endif
    end
  end

  always_comb begin
    bus.data_out = '0;
    if ((int'(bus.row_read) < ROWS) && (int'(bus.col_read) < COLS))
      bus.data_out = board_q[bus.row_read][bus.col_read];
  end

  assign bus.current_col    = col_q;
  assign bus.current_player = player_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.game_over      = (state_q == WIN) || (state_q == DRAW);
  assign bus.draw           = (state_q == DRAW);
  assign bus.winner         = winner_q;
endmodule
